// File: rtl/wb_syscall_unit_pkg.sv
// Shared constants, state encodings and the power-of-ten table for the writeback syscall unit.
package wb_syscall_unit_pkg;

    localparam logic [31:0] CODE_PRINT_INT  = 32'd1;
    localparam logic [31:0] CODE_EXIT       = 32'd10;
    localparam logic [31:0] CODE_PRINT_CHAR = 32'd11;
    localparam logic [4:0]  LINK_REG        = 5'd31;

    localparam logic [7:0]  ASCII_MINUS = 8'h2D;
    localparam logic [7:0]  ASCII_ZERO  = 8'h30;

    localparam logic [3:0]  TOP_POW_IDX = 4'd9;

    typedef enum logic [2:0] {
        StIdle,
        StPrint,
        StChar,
        StDone,
        StHalted
    } unit_state_e;

    typedef enum logic [1:0] {
        SerIdle,
        SerSign,
        SerDigit,
        SerSend
    } ser_state_e;

    function automatic logic [31:0] pow10(input logic [3:0] idx);
        logic [31:0] val;
        case (idx)
            4'd0:    val = 32'd1;
            4'd1:    val = 32'd10;
            4'd2:    val = 32'd100;
            4'd3:    val = 32'd1000;
            4'd4:    val = 32'd10000;
            4'd5:    val = 32'd100000;
            4'd6:    val = 32'd1000000;
            4'd7:    val = 32'd10000000;
            4'd8:    val = 32'd100000000;
            default: val = 32'd1000000000;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/wb_syscall_unit_int_to_ascii.sv
// Serialises a signed 32-bit value as decimal ASCII bytes over a valid/ready handshake.
module wb_int_to_ascii
    import wb_syscall_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] value_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        byte_valid_o,
    output logic [7:0]  byte_data_o,
    input  logic        byte_ready_i
);

    ser_state_e  state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [3:0]  pow_idx_q, pow_idx_d;
    logic [3:0]  digit_q, digit_d;
    logic        emitted_q, emitted_d;
    logic [31:0] pow_val;

    assign pow_val = pow10(pow_idx_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SerIdle;
            mag_q     <= '0;
            pow_idx_q <= '0;
            digit_q   <= '0;
            emitted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            pow_idx_q <= pow_idx_d;
            digit_q   <= digit_d;
            emitted_q <= emitted_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mag_d        = mag_q;
        pow_idx_d    = pow_idx_q;
        digit_d      = digit_q;
        emitted_d    = emitted_q;
        done_o       = 1'b0;
        byte_valid_o = 1'b0;
        byte_data_o  = 8'h00;
        case (state_q)
            SerIdle: begin
                if (start_i) begin
                    mag_d     = value_i;
                    pow_idx_d = TOP_POW_IDX;
                    digit_d   = 4'd0;
                    emitted_d = 1'b0;
                    state_d   = SerSign;
                end
            end
            SerSign: begin
                // mag_q still holds the raw operand; negation as unsigned keeps 0x80000000 intact
                if (mag_q[31]) begin
                    byte_valid_o = 1'b1;
                    byte_data_o  = ASCII_MINUS;
                    if (byte_ready_i) begin
                        mag_d   = -mag_q;
                        state_d = SerDigit;
                    end
                end else begin
                    state_d = SerDigit;
                end
            end
            SerDigit: begin
                if (mag_q >= pow_val) begin
                    mag_d   = mag_q - pow_val;
                    digit_d = digit_q + 4'd1;
                end else if (digit_q != 4'd0 || emitted_q || pow_idx_q == 4'd0) begin
                    state_d = SerSend;
                end else begin
                    pow_idx_d = pow_idx_q - 4'd1;
                end
            end
            SerSend: begin
                byte_valid_o = 1'b1;
                byte_data_o  = ASCII_ZERO + {4'b0000, digit_q};
                if (byte_ready_i) begin
                    emitted_d = 1'b1;
                    if (pow_idx_q == 4'd0) begin
                        done_o  = 1'b1;
                        state_d = SerIdle;
                    end else begin
                        pow_idx_d = pow_idx_q - 4'd1;
                        digit_d   = 4'd0;
                        state_d   = SerDigit;
                    end
                end
            end
            default: state_d = SerIdle;
        endcase
    end

    assign busy_o = (state_q != SerIdle);

endmodule

// File: rtl/wb_syscall_unit.sv
// Writeback stage: register-file write port plus print_int/print_char/exit syscall execution.
module wb_syscall_unit
    import wb_syscall_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        syscallFlag3_i,
    input  logic [31:0] dataInput1_i,
    input  logic [31:0] dataOutput1_i,
    input  logic [4:0]  writeReg3_i,
    input  logic        memtoReg3_i,
    input  logic        regWrite3_i,
    input  logic        link3_i,
    input  logic [31:0] v0_i,
    input  logic [31:0] a0_i,
    output logic        rfWe_o,
    output logic [4:0]  rfWaddr_o,
    output logic [31:0] rfWdata_o,
    output logic        stall_o,
    output logic        halt_o,
    output logic        conValid_o,
    output logic [7:0]  conData_o,
    input  logic        conReady_i
);

    unit_state_e state_q, state_d;
    logic [7:0]  char_q, char_d;
    logic        ser_start;
    logic        ser_busy;
    logic        ser_done;
    logic        ser_valid;
    logic [7:0]  ser_data;
    logic        is_int, is_char, is_exit, known_code;

    assign is_int     = (v0_i == CODE_PRINT_INT);
    assign is_char    = (v0_i == CODE_PRINT_CHAR);
    assign is_exit    = (v0_i == CODE_EXIT);
    assign known_code = is_int | is_char | is_exit;

    assign rfWaddr_o = link3_i ? LINK_REG : writeReg3_i;
    assign rfWdata_o = memtoReg3_i ? dataInput1_i : dataOutput1_i;
    assign halt_o    = (state_q == StHalted);
    assign rfWe_o    = ~rst & regWrite3_i & ~halt_o & (rfWaddr_o != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            char_q  <= '0;
        end else begin
            state_q <= state_d;
            char_q  <= char_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        char_d    = char_q;
        ser_start = 1'b0;
        case (state_q)
            StIdle: begin
                if (syscallFlag3_i) begin
                    if (is_char) begin
                        char_d  = a0_i[7:0];
                        state_d = StChar;
                    end else if (is_int) begin
                        ser_start = 1'b1;
                        state_d   = StPrint;
                    end else if (is_exit) begin
                        state_d = StHalted;
                    end
                end
            end
            StPrint:  if (ser_done) state_d = StDone;
            StChar:   if (conReady_i) state_d = StDone;
            // Syscall flag is still asserted here; the pipeline advances past it this cycle
            StDone:   state_d = StIdle;
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
    end

    assign stall_o = ~rst & ((state_q == StPrint) | (state_q == StChar) | (state_q == StHalted)
                     | ser_busy | ((state_q == StIdle) & syscallFlag3_i & known_code));

    assign conValid_o = (state_q == StChar) | ser_valid;
    assign conData_o  = (state_q == StChar) ? char_q : ser_data;

    wb_int_to_ascii u_int_to_ascii (
        .clk          (clk),
        .rst          (rst),
        .start_i      (ser_start),
        .value_i      (a0_i),
        .busy_o       (ser_busy),
        .done_o       (ser_done),
        .byte_valid_o (ser_valid),
        .byte_data_o  (ser_data),
        .byte_ready_i (conReady_i)
    );

endmodule

// File: doc/wb_syscall_unit.md
Name: wb_syscall_unit

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Drives the register-file write port: selects load data or ALU result, and forces `$ra` on link.
- Executes syscalls reaching WB: print_int, print_char and exit.
- Streams ASCII bytes to a console over a valid/ready handshake and stalls the pipeline until each syscall completes.

Parameters:
- CODE_PRINT_INT, 1, `$v0` value selecting signed-decimal print of `$a0`
- CODE_EXIT, 10, `$v0` value selecting halt
- CODE_PRINT_CHAR, 11, `$v0` value selecting print of `$a0[7:0]`
- LINK_REG, 31, destination register forced when link is set

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- syscallFlag3_i  in  1  syscall instruction in WB
- dataInput1_i  in  32  load data from memory
- dataOutput1_i  in  32  ALU result (PC+8 for link instructions)
- writeReg3_i  in  5  destination register
- memtoReg3_i  in  1  1 = write load data, 0 = write ALU result
- regWrite3_i  in  1  register write enable
- link3_i  in  1  link instruction
- v0_i  in  32  register file read of `$v0`
- a0_i  in  32  register file read of `$a0`
- rfWe_o  out  1  register file write enable
- rfWaddr_o  out  5  register file write address
- rfWdata_o  out  32  register file write data
- stall_o  out  1  freeze PC and all pipeline registers
- halt_o  out  1  program exited (sticky)
- conValid_o  out  1  console byte valid
- conData_o  out  8  console byte
- conReady_i  in  1  console accepts byte

Behaviour:
- Reset (async, rst=1): state=IDLE, halt_o=0, conValid_o=0, conData_o=0, all internal registers cleared. rfWe_o=0 and stall_o=0 while rst is high.
- Write path (combinational):
  - rfWe_o = regWrite3_i & ~halt_o & (rfWaddr_o≠0).
  - rfWaddr_o = link3_i ? LINK_REG : writeReg3_i.
  - rfWdata_o = memtoReg3_i ? dataInput1_i : dataOutput1_i.
- States: IDLE, SIGN, DIGIT, SEND, CHAR, DONE, HALTED.
- IDLE, syscallFlag3_i=1:
  - `$v0`=PRINT_CHAR: latch `a0[7:0]` → CHAR.
  - `$v0`=PRINT_INT: latch a0 → SIGN.
  - `$v0`=EXIT → HALTED.
  - Any other code: no-op, no stall, stay IDLE.
- stall_o = (state∈{SIGN,DIGIT,SEND,CHAR,HALTED}) | (state=IDLE & syscallFlag3_i & code∈{1,10,11}). It is therefore high in the same cycle the syscall is first seen.
- CHAR:
  - conValid_o=1, conData_o=latched byte.
  - On conValid_o & conReady_i → DONE.
- SIGN:
  - If a0<0 (signed): emit '-' (0x2D) with handshake; magnitude = two's-complement negate as 32-bit unsigned. 0x80000000 yields 2147483648, which is correct.
  - Otherwise skip the emit.
  - Then load power index p=9 (10^9) → DIGIT.
- DIGIT:
  - Repeated subtraction, one per cycle: while magnitude ≥ 10^p, subtract 10^p and increment digit (0..9).
  - When done: if digit≠0, or a digit was already emitted, or p=0 → SEND. Otherwise decrement p, stay in DIGIT.
  - Leading zeros are suppressed; a value of 0 prints "0".
- SEND:
  - conValid_o=1, conData_o=0x30+digit, held stable until conReady_i.
  - On accept: if p=0 → DONE; else p−1, digit=0 → DIGIT.
- DONE:
  - One cycle with stall_o=0 so the pipeline advances past the syscall.
  - syscallFlag3_i is ignored in this cycle; → IDLE.
- HALTED:
  - halt_o=1, stall_o=1, rfWe_o=0, conValid_o=0.
  - Left only by rst.
- Handshake rules:
  - Once conValid_o rises, conData_o is held until accepted.
  - conValid_o is never dropped without acceptance, except by rst.
- Register writes accompanying a syscall (regWrite3_i=1) pass through unchanged; syscalls normally carry regWrite=0.
- Reset mid-print: the byte stream is aborted immediately and no further bytes are emitted.

Decomposition:
- Shared package holds:
  - Syscall code constants.
  - State enum.
  - ASCII constants ('-', '0').
  - The 10-entry 32-bit power-of-ten table.
- Natural sub-module: `wb_int_to_ascii`, the SIGN/DIGIT/SEND serializer with a start/busy/done interface and a byte valid/ready output.

Test Plan:
- regWrite=1, memtoReg=1, writeReg=8, dataInput=0xDEADBEEF → rfWe=1, waddr=8, wdata=0xDEADBEEF. Same with writeReg=0 → rfWe=0. link=1, dataOutput=0x00400010 → waddr=31, wdata=0x00400010.
- syscall `$v0`=11, `$a0`=0x41, conReady held 0 for 3 cycles then 1 → one byte 0x41 held stable; stall high throughout, low for exactly the DONE cycle.
- syscall `$v0`=1, `$a0`=−2147483648, conReady=1 → bytes "-2147483648" (11 bytes) in order; single DONE cycle.
- syscall `$v0`=1, `$a0`=0 → single byte "0"; `$a0`=1005 → "1005" (inner zeros kept).
- syscall `$v0`=10 → halt_o=1 and stall_o=1 permanently; subsequent regWrite=1 gives rfWe=0. Syscall with `$v0`=5 → no stall, no bytes.
- rst asserted mid-print of 12345 after "12" → conValid_o=0 asynchronously, state IDLE, no further bytes after release.
